// File: rtl/eq_band_mixer_pkg.sv
// +-----------------------------------------------------------------------+
// | eq_band_mixer_pkg : shared constants, FSM encodings, band slice helper |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

package eq_band_mixer_pkg;

  localparam int NUM_BANDS = 10;
  localparam int DATA_W    = 24;
  localparam int GAIN_W    = 16;
  localparam int GAIN_FRAC = 14;
  localparam int ACC_W     = 44;
  localparam int PROD_W    = DATA_W + GAIN_W;
  localparam int BUS_W     = NUM_BANDS * DATA_W;

  localparam logic signed [GAIN_W-1:0] GAIN_UNITY = 16'sh4000;
  localparam logic [3:0]               LAST_BAND  = 4'(NUM_BANDS - 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CAPT = 3'd1;
  localparam logic [2:0] ST_ACC  = 3'd2;
  localparam logic [2:0] ST_RND  = 3'd3;
  localparam logic [2:0] ST_OUT  = 3'd4;

  function automatic logic signed [DATA_W-1:0] band_at(input logic [BUS_W-1:0] bands,
                                                       input logic [3:0]       idx);
    return $signed(bands[idx*DATA_W +: DATA_W]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/eq_band_mixer_if.sv
// +-----------------------------------------------------------------------+
// | eq_band_mixer_if : sample/gain/result bundle of the band mixer        |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

interface eq_band_mixer_if;
  import eq_band_mixer_pkg::*;

  logic              sample_valid;
  logic [BUS_W-1:0]  band_in;
  logic              gain_wr_en;
  logic [3:0]        gain_addr;
  logic [GAIN_W-1:0] gain_wr_data;
  logic [DATA_W-1:0] audio_out;
  logic              out_valid;
  logic              busy;
  logic              sat_flag;
  logic              drop_flag;

  modport master (
    output sample_valid, band_in, gain_wr_en, gain_addr, gain_wr_data,
    input  audio_out, out_valid, busy, sat_flag, drop_flag
  );

  modport slave (
    input  sample_valid, band_in, gain_wr_en, gain_addr, gain_wr_data,
    output audio_out, out_valid, busy, sat_flag, drop_flag
  );

endinterface

`default_nettype wire

// File: rtl/eq_band_mixer_mac_unit.sv
// +-----------------------------------------------------------------------+
// | eq_mac_unit : signed MAC with clear, Q2.14 round-half-up and optional |
// | clipping selected by EQ_MIX_SAT_EN.   Revision: 1.0                   |
// +-----------------------------------------------------------------------+
`default_nettype none

module eq_mac_unit
  import eq_band_mixer_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] band_i,
  input  logic signed [GAIN_W-1:0] gain_i,
  output logic [DATA_W-1:0]        result_o,
  output logic                     sat_o
);

  localparam logic signed [ACC_W-1:0] c_round_half = ACC_W'(1) <<< (GAIN_FRAC - 1);

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  w_sum, w_r;

  assign w_prod = PROD_W'(band_i) * PROD_W'(gain_i);
  assign w_sum  = acc_q + c_round_half;
  assign w_r    = w_sum >>> GAIN_FRAC;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_W'(w_prod);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

`ifdef EQ_MIX_SAT_EN
  logic w_pos_ovf, w_neg_ovf;

  // Out of range whenever the bits above the 24-bit sign do not all match it.
  assign w_pos_ovf = ~w_r[ACC_W-1] &  (|w_r[ACC_W-2:DATA_W-1]);
  assign w_neg_ovf =  w_r[ACC_W-1] & ~(&w_r[ACC_W-2:DATA_W-1]);
  assign result_o  = w_pos_ovf ? {1'b0, {(DATA_W-1){1'b1}}} :
                     w_neg_ovf ? {1'b1, {(DATA_W-1){1'b0}}} :
                                 w_r[DATA_W-1:0];
  assign sat_o     = w_pos_ovf | w_neg_ovf;
`else
  logic [ACC_W-DATA_W-1:0] w_unused_hi;

  assign w_unused_hi = w_r[ACC_W-1:DATA_W];
  assign result_o    = w_r[DATA_W-1:0];
  assign sat_o       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/eq_band_mixer.sv
// +-----------------------------------------------------------------------+
// | eq_band_mixer : per-band gain and recombination of 10 EQ bands, one   |
// | band per clock; clipping via EQ_MIX_SAT_EN.   Revision: 1.0           |
// +-----------------------------------------------------------------------+
`default_nettype none

module eq_band_mixer
  import eq_band_mixer_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  eq_band_mixer_if.slave bus
);

  logic [2:0]               state_q, state_d;
  logic [3:0]               idx_q, idx_d;
  logic [BUS_W-1:0]         band_q;
  logic signed [GAIN_W-1:0] gain_q     [NUM_BANDS];
  logic signed [GAIN_W-1:0] gain_act_q [NUM_BANDS];
  logic [DATA_W-1:0]        audio_q;
  logic                     sat_q, drop_q;

  logic              w_start;
  logic              w_acc_clr, w_acc_en, w_ld_out, w_busy, w_out_valid;
  logic [DATA_W-1:0] w_result;
  logic              w_sat;

  assign w_start = (state_q == ST_IDLE) && bus.sample_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.sample_valid) state_d = ST_CAPT;
      ST_CAPT: state_d = ST_ACC;
      ST_ACC:  if (idx_q == LAST_BAND) state_d = ST_RND;
      ST_RND:  state_d = ST_OUT;
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    w_acc_clr   = (state_q == ST_CAPT);
    w_acc_en    = (state_q == ST_ACC);
    w_ld_out    = (state_q == ST_RND);
    w_out_valid = (state_q == ST_OUT);
    w_busy      = (state_q == ST_CAPT) || (state_q == ST_ACC) || (state_q == ST_RND);
  end

  always_comb begin
    idx_d = idx_q;
    if (w_acc_clr) begin
      idx_d = '0;
    end else if (w_acc_en && (idx_q != LAST_BAND)) begin
      idx_d = idx_q + 4'd1;
    end
  end

  // Bands and the active gain set are frozen on the accepting edge, so a gain
  // write landing on that same edge only reaches the shadow copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      band_q <= '0;
    end else begin
      idx_q <= idx_d;
      if (w_start) band_q <= bus.band_in;
    end
  end

  for (genvar k = 0; k < NUM_BANDS; k++) begin : g_gain
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        gain_q[k]     <= GAIN_UNITY;
        gain_act_q[k] <= GAIN_UNITY;
      end else begin
        if (bus.gain_wr_en && (bus.gain_addr == 4'(k))) gain_q[k] <= bus.gain_wr_data;
        if (w_start) gain_act_q[k] <= gain_q[k];
      end
    end
  end

  eq_mac_unit u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (w_acc_clr),
    .en_i     (w_acc_en),
    .band_i   (band_at(band_q, idx_q)),
    .gain_i   (gain_act_q[idx_q]),
    .result_o (w_result),
    .sat_o    (w_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      audio_q <= '0;
      sat_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      if (w_ld_out) begin
        audio_q <= w_result;
        if (w_sat) sat_q <= 1'b1;
      end
      if (bus.sample_valid && (state_q != ST_IDLE)) drop_q <= 1'b1;
    end
  end

  assign bus.audio_out = audio_q;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.sat_flag  = sat_q;
  assign bus.drop_flag = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_eq_band_mixer.sv
// +-----------------------------------------------------------------------+
// | tb_eq_band_mixer : randomized self-checking bench for eq_band_mixer;  |
// | follows EQ_MIX_SAT_EN for clip expectations.   Revision: 1.0          |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_eq_band_mixer;
  import eq_band_mixer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  eq_band_mixer_if bus ();

  eq_band_mixer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic signed [GAIN_W-1:0] mg [NUM_BANDS];
  bit                       sat_m;

  // Mixed output from plain integer arithmetic on the model gains.
  function automatic logic [DATA_W-1:0] ref_out(input logic [BUS_W-1:0] b, output bit clip);
    longint s, r;
    logic signed [DATA_W-1:0] x;
    logic [DATA_W-1:0] o;
    s = 0;
    for (int k = 0; k < NUM_BANDS; k++) begin
      x = b[k*DATA_W +: DATA_W];
      s += longint'(x) * longint'(mg[k]);
    end
    r = (s + 64'sd8192) >>> 14;
    clip = 1'b0;
    o = r[DATA_W-1:0];
`ifdef EQ_MIX_SAT_EN
    if (r > 64'sd8388607) begin
      o = 24'h7FFFFF; clip = 1'b1;
    end else if (r < -64'sd8388608) begin
      o = 24'h800000; clip = 1'b1;
    end
`endif
    return o;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NUM_BANDS; k++) mg[k] = GAIN_UNITY;
    sat_m = 1'b0;
    @(negedge clk);
  endtask

  task automatic write_gain(input logic [3:0] addr, input logic [GAIN_W-1:0] data);
    @(negedge clk);
    bus.gain_wr_en = 1'b1; bus.gain_addr = addr; bus.gain_wr_data = data;
    if (addr < 4'(NUM_BANDS)) mg[addr] = data;
    @(negedge clk);
    bus.gain_wr_en = 1'b0;
  endtask

  // Strobes one sample and watches 20 cycles; lat counts cycles after the strobe edge.
  task automatic run_sample(input logic [BUS_W-1:0] b, output logic [DATA_W-1:0] v,
                            output int lat, output int nv, output logic busy1);
    @(negedge clk);
    bus.sample_valid = 1'b1; bus.band_in = b;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    busy1 = bus.busy; lat = -1; nv = 0; v = '0;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) @(negedge clk);
      if (bus.out_valid) begin
        nv++;
        if (lat < 0) begin lat = i; v = bus.audio_out; end
      end
    end
  endtask

  logic [DATA_W-1:0] v, e;
  int lat, nv;
  logic busy1;
  bit clip;

  task automatic test_reset();
    logic [BUS_W-1:0] b;
    do_reset();
    tests_run += 5;
    if (bus.audio_out !== 24'h0) begin tests_failed++; $display("FAIL reset_audio got %h want 000000", bus.audio_out); end
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    if (bus.sat_flag !== 1'b0) begin tests_failed++; $display("FAIL reset_sat got %b want 0", bus.sat_flag); end
    if (bus.drop_flag !== 1'b0) begin tests_failed++; $display("FAIL reset_drop got %b want 0", bus.drop_flag); end
    for (int k = 0; k < NUM_BANDS; k++) begin
      b = '0;
      b[k*DATA_W +: DATA_W] = 24'h000123 + 24'(k);
      run_sample(b, v, lat, nv, busy1);
      tests_run++;
      if (v !== 24'h000123 + 24'(k))
        begin tests_failed++; $display("FAIL reset_gain%0d got %h want %h", k, v, 24'h000123 + 24'(k)); end
    end
  endtask

  task automatic test_unity_sum();
    run_sample({NUM_BANDS{24'h010000}}, v, lat, nv, busy1);
    tests_run += 4;
    if (v !== 24'h0A0000) begin tests_failed++; $display("FAIL unity_value got %h want 0a0000", v); end
    if (lat != 13) begin tests_failed++; $display("FAIL unity_latency got %0d want 13", lat); end
    if (nv != 1) begin tests_failed++; $display("FAIL unity_pulses got %0d want 1", nv); end
    if (busy1 !== 1'b1) begin tests_failed++; $display("FAIL unity_busy got %b want 1", busy1); end
  endtask

  task automatic test_gain_round();
    logic [DATA_W-1:0] ins  [4] = '{24'h200000, 24'h000001, 24'hFFFFFF, 24'h000003};
    logic [DATA_W-1:0] outs [4] = '{24'h100000, 24'h000001, 24'h000000, 24'h000002};
    logic [BUS_W-1:0] b;
    write_gain(4'd0, 16'h2000);
    for (int k = 1; k < NUM_BANDS; k++) write_gain(4'(k), 16'h0000);
    for (int i = 0; i < 4; i++) begin
      b = {BUS_W{1'b1}};
      b[DATA_W-1:0] = ins[i];
      run_sample(b, v, lat, nv, busy1);
      tests_run++;
      if (v !== outs[i]) begin tests_failed++; $display("FAIL round_%0d got %h want %h", i, v, outs[i]); end
    end
    for (int k = 0; k < NUM_BANDS; k++) write_gain(4'(k), GAIN_UNITY);
  endtask

  task automatic test_random();
    logic [BUS_W-1:0] b;
    for (int it = 0; it < 16; it++) begin
      repeat (2) write_gain(4'($urandom_range(0, 15)), 16'($urandom));
      for (int k = 0; k < NUM_BANDS; k++) begin
        b[k*DATA_W +: DATA_W] = 24'($urandom);
        if (it[0]) b[k*DATA_W +: DATA_W] = 24'($signed(b[k*DATA_W +: DATA_W]) >>> 5);
      end
      e = ref_out(b, clip);
      sat_m |= clip;
      run_sample(b, v, lat, nv, busy1);
      tests_run++;
      if (v !== e || lat != 13) begin tests_failed++; $display("FAIL random_%0d got %h lat %0d want %h lat 13", it, v, lat, e); end
    end
    tests_run++;
    if (bus.sat_flag !== sat_m) begin tests_failed++; $display("FAIL random_sat got %b want %b", bus.sat_flag, sat_m); end
    for (int k = 0; k < NUM_BANDS; k++) write_gain(4'(k), GAIN_UNITY);
  endtask

  task automatic test_saturation();
    run_sample({NUM_BANDS{24'h400000}}, v, lat, nv, busy1);
    tests_run++;
`ifdef EQ_MIX_SAT_EN
    e = 24'h7FFFFF;
`else
    e = 24'h800000;
`endif
    if (v !== e) begin tests_failed++; $display("FAIL sat_pos got %h want %h", v, e); end
    run_sample({NUM_BANDS{24'hC00000}}, v, lat, nv, busy1);
    tests_run += 2;
    if (v !== 24'h800000) begin tests_failed++; $display("FAIL sat_neg got %h want 800000", v); end
`ifdef EQ_MIX_SAT_EN
    sat_m = 1'b1;
`endif
    if (bus.sat_flag !== sat_m) begin tests_failed++; $display("FAIL sat_flag got %b want %b", bus.sat_flag, sat_m); end
  endtask

  task automatic test_drop();
    logic [BUS_W-1:0] a, b;
    int cnt;
    logic [DATA_W-1:0] got;
    for (int k = 0; k < NUM_BANDS; k++) begin
      a[k*DATA_W +: DATA_W] = 24'($urandom_range(0, 24'h0FFFFF));
      b[k*DATA_W +: DATA_W] = 24'($urandom_range(0, 24'h0FFFFF)) | 24'h000001;
    end
    e = ref_out(a, clip);
    cnt = 0; got = '0;
    @(negedge clk);
    bus.sample_valid = 1'b1; bus.band_in = a;
    for (int i = 1; i <= 35; i++) begin
      @(negedge clk);
      bus.sample_valid = (i == 3);
      if (i == 3) bus.band_in = b;
      if (bus.out_valid) begin cnt++; got = bus.audio_out; end
    end
    tests_run += 3;
    if (cnt != 1) begin tests_failed++; $display("FAIL drop_count got %0d want 1", cnt); end
    if (got !== e) begin tests_failed++; $display("FAIL drop_value got %h want %h", got, e); end
    if (bus.drop_flag !== 1'b1) begin tests_failed++; $display("FAIL drop_flag got %b want 1", bus.drop_flag); end
  endtask

  task automatic test_gain_timing_reset();
    logic [BUS_W-1:0] b;
    logic [DATA_W-1:0] e_new, got;
    logic [GAIN_W-1:0] g;
    int cnt;
    for (int k = 0; k < NUM_BANDS; k++) b[k*DATA_W +: DATA_W] = 24'($urandom_range(0, 24'h3FFFF));
    e = ref_out(b, clip);
    g = 16'($urandom_range(16'h0800, 16'h3000));
    cnt = 0; got = '0;
    @(negedge clk);
    bus.sample_valid = 1'b1; bus.band_in = b;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      bus.sample_valid = 1'b0;
      bus.gain_wr_en = (i == 5); bus.gain_addr = 4'd3; bus.gain_wr_data = g;
      if (bus.out_valid) begin cnt++; got = bus.audio_out; end
    end
    mg[3] = g;
    e_new = ref_out(b, clip);
    tests_run++;
    if (got !== e || cnt != 1) begin tests_failed++; $display("FAIL gain_old got %h n %0d want %h n 1", got, cnt, e); end
    run_sample(b, v, lat, nv, busy1);
    tests_run++;
    if (v !== e_new) begin tests_failed++; $display("FAIL gain_new got %h want %h", v, e_new); end

    cnt = 0;
    @(negedge clk);
    bus.sample_valid = 1'b1; bus.band_in = b;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      bus.sample_valid = 1'b0;
      if (i == 6) rst_n = 1'b0;
      if (i == 8) rst_n = 1'b1;
      if (bus.out_valid) cnt++;
    end
    for (int k = 0; k < NUM_BANDS; k++) mg[k] = GAIN_UNITY;
    tests_run += 3;
    if (cnt != 0) begin tests_failed++; $display("FAIL rst_valid got %0d want 0", cnt); end
    if (bus.audio_out !== 24'h0) begin tests_failed++; $display("FAIL rst_audio got %h want 000000", bus.audio_out); end
    if (bus.drop_flag !== 1'b0) begin tests_failed++; $display("FAIL rst_drop got %b want 0", bus.drop_flag); end
    e = ref_out(b, clip);
    run_sample(b, v, lat, nv, busy1);
    tests_run++;
    if (v !== e) begin tests_failed++; $display("FAIL rst_gains got %h want %h", v, e); end
  endtask

  initial begin
    bus.sample_valid = 1'b0; bus.band_in = '0;
    bus.gain_wr_en = 1'b0; bus.gain_addr = '0; bus.gain_wr_data = '0;
    test_reset();
    test_unity_sum();
    test_gain_round();
    test_random();
    test_saturation();
    test_drop();
    test_gain_timing_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
